// File: rtl/cim_rio_driver_if.sv
// Signal bundle between the AES core (master) and the compute-in-memory read-out driver (slave).
// Lane-indexed S-box addresses and read-out buses are carried as 16-entry arrays.
interface cim_rio_driver_if;
  logic         START;
  logic         KWE;
  logic [3:0]   KADDR;
  logic [127:0] KDATA;
  logic [15:0]  IN;
  logic [2:0]   DEMUX_ADD   [16];
  logic [5:0]   RWL_DEC_ADD [16];
  logic [7:0]   RIO         [16];
  logic         LKP;
  logic [3:0]   RND;
  logic         BUSY;
  logic         DONE;

  modport master (
    output START, KWE, KADDR, KDATA, IN, DEMUX_ADD, RWL_DEC_ADD,
    input  RIO, LKP, RND, BUSY, DONE
  );

  modport slave (
    input  START, KWE, KADDR, KDATA, IN, DEMUX_ADD, RWL_DEC_ADD,
    output RIO, LKP, RND, BUSY, DONE
  );
endinterface

// File: rtl/cim_rio_driver.sv
// CIM read-out driver: round-key store, AddRoundKey bit-plane window and S-box lookup
// feeding the 16 RIO buses back to the AES core.
//
// state  | meaning
// IDLE   | waiting for START; round-key writes accepted
// ARK    | AddRoundKey window, ARK_CYC cycles per round
// LOOKUP | one-cycle S-box read, advances the round index
// FIN    | one-cycle DONE pulse, then back to IDLE
module cim_rio_driver #(
  parameter int NROUNDS = 10,
  parameter int ARK_CYC = 8
) (
  input logic             CLK,
  input logic             RST,
  cim_rio_driver_if.slave bus
);
  localparam int              CW       = (ARK_CYC > 1) ? $clog2(ARK_CYC) : 1;
  localparam logic [3:0]      LAST_RND = 4'(NROUNDS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ARK_CYC - 1);

  // FIPS-197 forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_ARK, S_LOOKUP, S_FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    rnd;
  logic          lkp;
  logic          busy;
  logic          done;
  logic [127:0]  rkey;
  logic [127:0]  key_mem [NROUNDS+1];
  logic [7:0]    rio_q   [16];
  logic [7:0]    ark_val [16];
  logic [7:0]    lk_val  [16];

  // Lane k carries bit (7-k) of the even key bytes, lane k+8 of the odd bytes; byte 0 in the MSB
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      ark_val[k]   = 8'h00;
      ark_val[k+8] = 8'h00;
      for (int i = 0; i < 8; i++) begin
        ark_val[k][7-i]   = rkey[127 - 16*i - k] ^ bus.IN[k+8];
        ark_val[k+8][7-i] = rkey[119 - 16*i - k] ^ bus.IN[k];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      lk_val[j] = 8'h00;
      if (!bus.DEMUX_ADD[j][2])
        lk_val[j] = SBOX_ROM[2047 - 8*int'({bus.DEMUX_ADD[j][1:0], bus.RWL_DEC_ADD[j]}) -: 8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      rnd   <= 4'd0;
      lkp   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rkey  <= '0;
      for (int i = 0; i <= NROUNDS; i++) key_mem[i] <= '0;
      for (int j = 0; j < 16; j++) rio_q[j] <= 8'h00;
    end else begin
      if (state == S_IDLE && bus.KWE && bus.KADDR <= LAST_RND)
        key_mem[bus.KADDR] <= bus.KDATA;
      case (state)
        S_IDLE: begin
          lkp  <= 1'b0;
          done <= 1'b0;
          if (bus.START) begin
            // key 0 is captured here, so a same-edge write to key 0 is not seen by this pass
            state <= S_ARK;
            rnd   <= 4'd0;
            cnt   <= '0;
            busy  <= 1'b1;
            rkey  <= key_mem[0];
          end
        end
        S_ARK: begin
          for (int j = 0; j < 16; j++) rio_q[j] <= ark_val[j];
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rnd < LAST_RND) begin
              state <= S_LOOKUP;
              lkp   <= 1'b1;
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOOKUP: begin
          for (int j = 0; j < 16; j++) rio_q[j] <= lk_val[j];
          rnd   <= rnd + 4'd1;
          rkey  <= key_mem[rnd + 4'd1];
          lkp   <= 1'b0;
          state <= S_ARK;
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.RIO  = rio_q;
  assign bus.LKP  = lkp;
  assign bus.RND  = rnd;
  assign bus.BUSY = busy;
  assign bus.DONE = done;
endmodule

// File: tb/tb_cim_rio_driver.sv
// Randomized bench for cim_rio_driver against a pass-position model: the S-box and round keys
// are derived from GF(2^8) arithmetic and the AES key schedule rather than copied tables.
module tb_cim_rio_driver;
  localparam int NR = 10;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cim_rio_driver_if bus ();
  cim_rio_driver #(.NROUNDS(NR), .ARK_CYC(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int           n_chk  = 0;
  int           n_fail = 0;
  int           sweep  = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] rk     [NR+1];
  logic [127:0] kst    [NR+1];
  logic [127:0] m_rkey;
  logic         m_act;
  int           m_pos;
  logic [3:0]   m_rnd;
  logic [7:0]   m_rio  [16];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Position p counts edges since START: 9 positions per round, the 9th is the lookup,
  // except after the last round where it is the completion cycle. 0=ARK 1=LOOKUP 2=FIN
  function automatic int phase(input int p);
    if (p % 9 != 8) return 0;
    return (p / 9 < NR) ? 1 : 2;
  endfunction

  function automatic logic [7:0] ark_lane(input logic [127:0] key, input logic [15:0] din, input int lane);
    logic [7:0] v, kb;
    logic       x;
    int         k, odd;
    k   = lane % 8;
    odd = (lane < 8) ? 0 : 1;
    x   = (lane < 8) ? din[k+8] : din[k];
    for (int i = 0; i < 8; i++) begin
      kb       = key[127 - 8*(2*i + odd) -: 8];
      v[7-i]   = kb[7-k] ^ x;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_pos = 0; m_rnd = 4'd0; m_rkey = '0;
    for (int j = 0; j < 16; j++) m_rio[j] = 8'h00;
    for (int i = 0; i <= NR; i++) kst[i] = '0;
  endtask

  task automatic model_edge();
    if (!m_act) begin
      if (bus.START) begin
        m_act = 1'b1; m_pos = 0; m_rnd = 4'd0; m_rkey = kst[0];
      end
      if (bus.KWE && bus.KADDR <= 4'(NR)) kst[bus.KADDR] = bus.KDATA;
    end else begin
      case (phase(m_pos))
        0: for (int j = 0; j < 16; j++) m_rio[j] = ark_lane(m_rkey, bus.IN, j);
        1: begin
          for (int j = 0; j < 16; j++)
            m_rio[j] = bus.DEMUX_ADD[j][2] ? 8'h00 : sbox_m[{bus.DEMUX_ADD[j][1:0], bus.RWL_DEC_ADD[j]}];
          m_rkey = kst[m_pos/9 + 1];
        end
        default: m_act = 1'b0;
      endcase
      if (m_act) begin
        m_pos++;
        m_rnd = 4'(m_pos / 9);
      end
    end
  endtask

  task automatic check_outputs();
    logic [127:0] got, exp;
    for (int j = 0; j < 16; j++) begin
      got[8*j +: 8] = bus.RIO[j];
      exp[8*j +: 8] = m_rio[j];
    end
    chk("rio", got, exp);
    chk("lkp", bus.LKP, m_act && phase(m_pos) == 1);
    chk("busy", bus.BUSY, m_act);
    chk("done", bus.DONE, m_act && phase(m_pos) == 2);
    chk("rnd", bus.RND, m_rnd);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic rand_inputs(input bit noise);
    bus.IN    = 16'($urandom);
    bus.START = noise && m_act && ($urandom_range(0, 7) == 0);
    bus.KWE   = noise && m_act && ($urandom_range(0, 3) == 0);
    bus.KADDR = 4'($urandom);
    bus.KDATA = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 16; j++) begin
      logic [7:0] idx;
      if (m_act && phase(m_pos) == 1) begin
        idx = 8'(sweep);
        sweep++;
        bus.DEMUX_ADD[j]   = {($urandom_range(0, 7) == 0), idx[7:6]};
        bus.RWL_DEC_ADD[j] = idx[5:0];
      end else begin
        bus.DEMUX_ADD[j]   = 3'($urandom);
        bus.RWL_DEC_ADD[j] = 6'($urandom);
      end
    end
  endtask

  task automatic load_key(input logic [3:0] addr, input logic [127:0] data);
    rand_inputs(1'b0);
    bus.KWE = 1'b1; bus.KADDR = addr; bus.KDATA = data;
    step();
    bus.KWE = 1'b0;
  endtask

  task automatic run_pass(input bit kw, input logic [3:0] ka, input logic [127:0] kd,
                          input int abort_at, input bit directed,
                          output int done_e, output int lkp_n);
    bit          lk_pending, lk_now;
    logic [31:0] sel;
    lk_pending = directed;
    done_e = -1;
    lkp_n  = 0;
    rand_inputs(1'b0);
    bus.START = 1'b1; bus.KWE = kw; bus.KADDR = ka; bus.KDATA = kd;
    step();
    for (int e = 1; e <= 100; e++) begin
      if (e == abort_at) return;
      rand_inputs(1'b1);
      if (directed && e == 1) bus.IN = 16'h0000;
      if (directed && e == 2) bus.IN = 16'h0180;
      lk_now = lk_pending && m_act && phase(m_pos) == 1;
      if (lk_now) begin
        bus.DEMUX_ADD[3]  = 3'b000; bus.RWL_DEC_ADD[3]  = 6'h00;
        bus.DEMUX_ADD[5]  = 3'b010; bus.RWL_DEC_ADD[5]  = 6'h00;
        bus.DEMUX_ADD[9]  = 3'b001; bus.RWL_DEC_ADD[9]  = 6'h13;
        bus.DEMUX_ADD[12] = 3'b100; bus.RWL_DEC_ADD[12] = 6'h3F;
      end
      step();
      sel = {bus.RIO[0], bus.RIO[15], bus.RIO[14], bus.RIO[7]};
      if (directed && e == 1) chk("ark_in0000", sel, 32'h00ff5500);
      if (directed && e == 2) chk("ark_in0180", sel, 32'hff005500);
      if (lk_now) begin
        chk("lookup_lanes", {bus.RIO[3], bus.RIO[5], bus.RIO[9], bus.RIO[12]}, 32'h63cded00);
        lk_pending = 1'b0;
      end
      if (bus.LKP === 1'b1) lkp_n++;
      if (bus.DONE === 1'b1 && done_e < 0) done_e = e;
    end
  endtask

  initial begin
    int de, ln;
    RST = 1'b1;
    bus.START = 1'b0; bus.KWE = 1'b0; bus.KADDR = 4'd0; bus.KDATA = '0; bus.IN = 16'h0;
    for (int j = 0; j < 16; j++) begin
      bus.DEMUX_ADD[j] = 3'd0; bus.RWL_DEC_ADD[j] = 6'd0;
    end
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    model_reset();
    #2;
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
    rand_inputs(1'b0);
    step();

    // key 0 only, directed ARK bit-plane and lookup lanes
    load_key(4'd0, rk[0]);
    run_pass(1'b0, 4'd0, '0, 0, 1'b1, de, ln);
    chk("done_edge_p1", de, 98);
    chk("lkp_count_p1", ln, 10);

    // full key schedule; out-of-range writes ignored; same-edge write to key 0 not seen
    for (int r = 0; r <= NR; r++) load_key(4'(r), rk[r]);
    load_key(4'd11, {$urandom, $urandom, $urandom, $urandom});
    load_key(4'd15, {$urandom, $urandom, $urandom, $urandom});
    run_pass(1'b1, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, de, ln);
    chk("done_edge_p2", de, 98);
    chk("lkp_count_p2", ln, 10);
    chk("busy_after_p2", bus.BUSY, 1'b0);

    // same-edge write to key 5 is used by this pass
    run_pass(1'b1, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, de, ln);
    chk("done_edge_p3", de, 98);

    // abort mid-pass
    run_pass(1'b0, 4'd0, '0, 40, 1'b0, de, ln);
    RST = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    RST = 1'b0;
    rand_inputs(1'b0);
    step();

    // cleared key store
    run_pass(1'b0, 4'd0, '0, 0, 1'b0, de, ln);
    chk("done_edge_p4", de, 98);

    // reload and restart from round 0
    for (int r = 0; r <= NR; r++) load_key(4'(r), rk[r]);
    run_pass(1'b0, 4'd0, '0, 0, 1'b0, de, ln);
    chk("done_edge_p5", de, 98);
    chk("lkp_count_p5", ln, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
